// File: rtl/h14tx_pkg.sv
// rtl/h14tx_pkg.sv - shared TMDS types, control tokens and symbol helpers
package h14tx_pkg;

  typedef logic [9:0]        symbol_t;
  typedef logic [7:0]        video_t;
  typedef logic signed [4:0] disp_t;

  localparam symbol_t CTRL_TOKEN_0 = 10'b1101010100;
  localparam symbol_t CTRL_TOKEN_1 = 10'b0010101011;
  localparam symbol_t CTRL_TOKEN_2 = 10'b0101010100;
  localparam symbol_t CTRL_TOKEN_3 = 10'b1010101011;

  typedef enum logic [1:0] {LOCK_SEARCH, LOCK_VERIFY, LOCK_LOCKED} tmds_lock_e;

  // Ones minus zeros over all ten bits, range -10..+10.
  function automatic disp_t tmds_disparity(symbol_t s);
    disp_t d;
    d = -5'sd10;
    for (int i = 0; i < 10; i++) begin
      if (s[i]) d = d + 5'sd2;
    end
    return d;
  endfunction

  function automatic video_t tmds_decode(symbol_t s);
    video_t d;
    video_t v;
    d    = s[9] ? ~s[7:0] : s[7:0];
    v[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      v[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return v;
  endfunction

endpackage

// File: rtl/h14tx_decoding_tmds_if.sv
// rtl/h14tx_decoding_tmds_if.sv - symbol input and decoded output bundle of the TMDS decoder
interface h14tx_decoding_tmds_if;
  import h14tx_pkg::*;

  symbol_t    symbol;
  video_t     video;
  logic [1:0] ctrl;
  logic       de;
  logic       disp_err;
  logic       locked;
  logic       bitslip;

  modport master (output symbol, input video, ctrl, de, disp_err, locked, bitslip);
  modport slave  (input symbol, output video, ctrl, de, disp_err, locked, bitslip);
endinterface

// File: rtl/h14tx_decoding_tmds_lock.sv
// rtl/h14tx_decoding_tmds_lock.sv - word-lock FSM with slip timeout, token run and error counters
module h14tx_decoding_tmds_lock
  import h14tx_pkg::*;
#(
  parameter int LOCK_COUNT   = 8,
  parameter int SLIP_TIMEOUT = 1024,
  parameter int ERR_LIMIT    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid,
  input  logic is_ctrl,
  input  logic disp_err,
  output logic locked,
  output logic bitslip
);

  localparam logic [15:0] TMO_MAX = 16'(SLIP_TIMEOUT - 1);
  localparam logic [7:0]  RUN_MAX = 8'(LOCK_COUNT - 1);
  localparam logic [7:0]  ERR_MAX = 8'(ERR_LIMIT - 1);

  tmds_lock_e  state, state_d;
  logic [15:0] tmo, tmo_d;
  logic [7:0]  run, run_d;
  logic [7:0]  errs, errs_d;
  logic        bitslip_d;

  always_comb begin
    state_d   = state;
    tmo_d     = tmo;
    run_d     = run;
    errs_d    = errs;
    bitslip_d = 1'b0;
    case (state)
      LOCK_SEARCH: begin
        if (valid && is_ctrl) begin
          tmo_d   = '0;
          run_d   = 8'd1;
          state_d = (LOCK_COUNT <= 1) ? LOCK_LOCKED : LOCK_VERIFY;
        end else if (tmo == TMO_MAX) begin
          // Restarting the count doubles as settle time after the slip.
          bitslip_d = 1'b1;
          tmo_d     = '0;
        end else begin
          tmo_d = tmo + 16'd1;
        end
      end
      LOCK_VERIFY: begin
        if (valid && is_ctrl) begin
          run_d = run + 8'd1;
          if (run == RUN_MAX) state_d = LOCK_LOCKED;
        end else if (valid) begin
          state_d = LOCK_SEARCH;
          run_d   = '0;
          tmo_d   = '0;
        end
      end
      LOCK_LOCKED: begin
        if (valid && is_ctrl) begin
          errs_d = '0;
        end else if (valid && disp_err) begin
          if (errs == ERR_MAX) begin
            state_d = LOCK_SEARCH;
            errs_d  = '0;
            run_d   = '0;
            tmo_d   = '0;
          end else begin
            errs_d = errs + 8'd1;
          end
        end
      end
      default: state_d = LOCK_SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOCK_SEARCH;
      tmo     <= '0;
      run     <= '0;
      errs    <= '0;
      locked  <= 1'b0;
      bitslip <= 1'b0;
    end else begin
      state   <= state_d;
      tmo     <= tmo_d;
      run     <= run_d;
      errs    <= errs_d;
      locked  <= (state_d == LOCK_LOCKED);
      bitslip <= bitslip_d;
    end
  end

endmodule

// File: rtl/h14tx_decoding_tmds.sv
// rtl/h14tx_decoding_tmds.sv - two-stage TMDS symbol decoder with disparity check and word lock
// Optional saturating error counter port under H14TX_TMDS_ERR_CNT_EN.
module h14tx_decoding_tmds
  import h14tx_pkg::*;
#(
  parameter int LOCK_COUNT   = 8,
  parameter int SLIP_TIMEOUT = 1024,
  parameter int ERR_LIMIT    = 4,
  parameter int DISP_LIMIT   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  h14tx_decoding_tmds_if.slave  tmds
`ifdef H14TX_TMDS_ERR_CNT_EN
  ,
  output logic [15:0]           err_count
`endif
);

  logic       m_ctrl;
  logic [1:0] m_code;

  symbol_t    s1_sym;
  logic       s1_vld;
  logic       s1_ctrl;
  logic [1:0] s1_code;
  disp_t      s1_disp;

  logic signed [7:0] acc, acc_sum;
  logic              over, err_d;

  video_t     video_q;
  logic [1:0] ctrl_q;
  logic       de_q, disp_err_q, locked_q, bitslip_q;

  always_comb begin
    m_ctrl = 1'b1;
    m_code = 2'd0;
    case (tmds.symbol)
      CTRL_TOKEN_0: m_code = 2'd0;
      CTRL_TOKEN_1: m_code = 2'd1;
      CTRL_TOKEN_2: m_code = 2'd2;
      CTRL_TOKEN_3: m_code = 2'd3;
      default:      m_ctrl = 1'b0;
    endcase
  end

  // s1_vld keeps the all-zero reset contents of stage 1 from being decoded as data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_sym  <= '0;
      s1_ctrl <= 1'b0;
      s1_code <= '0;
      s1_disp <= '0;
    end else begin
      s1_vld  <= 1'b1;
      s1_sym  <= tmds.symbol;
      s1_ctrl <= m_ctrl;
      s1_code <= m_code;
      s1_disp <= tmds_disparity(tmds.symbol);
    end
  end

  assign acc_sum = acc + {{3{s1_disp[4]}}, s1_disp};
  assign over    = (acc_sum > DISP_LIMIT) || (acc_sum < -DISP_LIMIT);
  assign err_d   = s1_vld && !s1_ctrl && over;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      video_q    <= '0;
      ctrl_q     <= '0;
      de_q       <= 1'b0;
      disp_err_q <= 1'b0;
    end else if (s1_vld && s1_ctrl) begin
      acc        <= '0;
      video_q    <= '0;
      ctrl_q     <= s1_code;
      de_q       <= 1'b0;
      disp_err_q <= 1'b0;
    end else if (s1_vld) begin
      acc        <= over ? 8'sd0 : acc_sum;
      video_q    <= locked_q ? tmds_decode(s1_sym) : '0;
      de_q       <= locked_q;
      disp_err_q <= over;
    end else begin
      video_q    <= '0;
      de_q       <= 1'b0;
      disp_err_q <= 1'b0;
    end
  end

  h14tx_decoding_tmds_lock #(
    .LOCK_COUNT   (LOCK_COUNT),
    .SLIP_TIMEOUT (SLIP_TIMEOUT),
    .ERR_LIMIT    (ERR_LIMIT)
  ) u_lock (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (s1_vld),
    .is_ctrl  (s1_ctrl),
    .disp_err (err_d),
    .locked   (locked_q),
    .bitslip  (bitslip_q)
  );

`ifdef H14TX_TMDS_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_d && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

  assign tmds.video    = video_q;
  assign tmds.ctrl     = ctrl_q;
  assign tmds.de       = de_q;
  assign tmds.disp_err = disp_err_q;
  assign tmds.locked   = locked_q;
  assign tmds.bitslip  = bitslip_q;

endmodule

// File: tb/tb_h14tx_decoding_tmds.sv
// tb/tb_h14tx_decoding_tmds.sv - directed and randomized checks of h14tx_decoding_tmds against a reference model
module tb_h14tx_decoding_tmds;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  h14tx_decoding_tmds_if bus();
`ifdef H14TX_TMDS_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  h14tx_decoding_tmds dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tmds  (bus)
`ifdef H14TX_TMDS_ERR_CNT_EN
    ,
    .err_count (err_count)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  logic [9:0] toks [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  // Reference model: mode 0 = hunting, 1 = counting tokens, 2 = aligned.
  int         m_acc, m_mode, m_run, m_errs, m_tmo, m_errcnt;
  logic [9:0] m_prev;
  bit         m_prev_v;
  logic [7:0] e_video;
  logic [1:0] e_ctrl;
  logic       e_de, e_derr, e_locked, e_bs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int tok_idx(input logic [9:0] s);
    for (int i = 0; i < 4; i++) if (s == toks[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] ref_decode(input logic [9:0] s);
    logic [7:0] d, v;
    d = s[9] ? ~s[7:0] : s[7:0];
    v[0] = d[0];
    for (int i = 1; i < 8; i++) v[i] = s[8] ? (d[i] ^ d[i-1]) : !(d[i] ^ d[i-1]);
    return v;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_mode = 0; m_run = 0; m_errs = 0; m_tmo = 0; m_errcnt = 0;
    m_prev = '0; m_prev_v = 0;
    e_video = '0; e_ctrl = '0; e_de = 0; e_derr = 0; e_locked = 0; e_bs = 0;
  endtask

  // One clock edge: the symbol applied on the previous step reaches the outputs.
  task automatic model_edge();
    int ti, na;
    bit derr, bs;
    ti = -1; derr = 0; bs = 0;
    e_video = '0; e_de = 0;
    if (m_prev_v) begin
      ti = tok_idx(m_prev);
      if (ti >= 0) begin
        e_ctrl = 2'(ti);
        m_acc  = 0;
      end else begin
        na = m_acc + 2 * $countones(m_prev) - 10;
        if (na > 16 || na < -16) begin
          derr = 1; m_acc = 0;
          if (m_errcnt < 65535) m_errcnt++;
        end else m_acc = na;
        e_de = (m_mode == 2);
        if (m_mode == 2) e_video = ref_decode(m_prev);
      end
    end
    e_derr = derr;
    case (m_mode)
      0: if (ti >= 0) begin m_mode = 1; m_run = 1; m_tmo = 0; end
         else if (m_tmo == 1023) begin bs = 1; m_tmo = 0; end
         else m_tmo++;
      1: if (ti >= 0) begin m_run++; if (m_run == 8) m_mode = 2; end
         else if (m_prev_v) begin m_mode = 0; m_run = 0; m_tmo = 0; end
      default: if (ti >= 0) m_errs = 0;
         else if (derr) begin
           m_errs++;
           if (m_errs == 4) begin m_mode = 0; m_errs = 0; m_run = 0; m_tmo = 0; end
         end
    endcase
    e_locked = (m_mode == 2);
    e_bs = bs;
  endtask

  task automatic check_all();
    chk("video", bus.video, e_video);
    chk("ctrl", bus.ctrl, e_ctrl);
    chk("de", bus.de, e_de);
    chk("disp_err", bus.disp_err, e_derr);
    chk("locked", bus.locked, e_locked);
    chk("bitslip", bus.bitslip, e_bs);
`ifdef H14TX_TMDS_ERR_CNT_EN
    chk("err_count", err_count, m_errcnt);
`endif
  endtask

  task automatic step(input logic [9:0] sym);
    bus.symbol = sym;
    @(posedge clk);
    model_edge();
    m_prev = sym; m_prev_v = 1;
    #1;
    check_all();
  endtask

  // Reset is asserted away from the clock edge so its asynchronous effect is visible.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n_slip;
    logic [9:0] r;
    bus.symbol = '0;
    #2;
    do_reset();

    // Eight ctrl-00 tokens reach lock.
    for (int i = 0; i < 8; i++) step(10'b1101010100);
    chk("pre_lock", bus.locked, 1'b0);
    // Data with disparity -8 then +10.
    step(10'b0100000000);
    chk("lock_rise", bus.locked, 1'b1);
    step(10'b1111111111);
    chk("t2_de", bus.de, 1'b1);
    step(10'b1101010100);
    chk("t2_de_b", bus.de, 1'b1);

    // Accumulator -8, -16, then violation on the third.
    for (int i = 0; i < 3; i++) step(10'b0100000000);
    chk("t3_no_err", bus.disp_err, 1'b0);
    step(10'b1101010100);
    chk("t3_err", bus.disp_err, 1'b1);

    // Four violations without a token drop lock.
    for (int i = 0; i < 13; i++) step(10'b0100000000);
    chk("t4_unlock", bus.locked, 1'b0);
    step(10'b0100000000);
    chk("t4_de", bus.de, 1'b0);

    // No tokens: bitslip every 1024 edges, never locked.
    do_reset();
    n_slip = 0;
    for (int e = 1; e <= 2100; e++) begin
      step(10'b1111111111);
      if (bus.bitslip === 1'b1) begin
        chk("slip_pos", 32'(e % 1024), 32'd0);
        n_slip++;
      end
    end
    chk("slip_cnt", n_slip, 2);

    // Violations spread across lock loss and relock.
    do_reset();
    for (int i = 0; i < 9; i++) step(10'b1101010100);
    for (int i = 0; i < 13; i++) step(10'b0100000000);
    for (int i = 0; i < 9; i++) step(10'b1101010100);
    for (int i = 0; i < 4; i++) step(10'b0100000000);
`ifdef H14TX_TMDS_ERR_CNT_EN
    chk("errcnt5", err_count, 16'd5);
    do_reset();
    chk("errcnt_rst", err_count, 16'd0);
`else
    do_reset();
`endif

    // Randomized mix with token bursts and a mid-run reset.
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) do_reset();
      if ($urandom_range(0, 39) == 0) begin
        for (int k = 0; k < 10; k++) step(toks[$urandom_range(0, 3)]);
      end
      case ($urandom_range(0, 9))
        0, 1, 2: r = toks[$urandom_range(0, 3)];
        3, 4:    r = ($urandom_range(0, 1) != 0) ? 10'h100 : 10'h3FF;
        default: r = 10'($urandom_range(0, 1023));
      endcase
      step(r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
